// File: rtl/spi_word_tx.sv
// spi_word_tx: streams 12-bit words from an upstream memory out as SPI mode-0
// frames (MSB first, one chip-select assertion per word, fixed CS gap).
// Optional receive capture of spi_miso is enabled by defining SPI_WORD_TX_RXCAP_EN.
module spi_word_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TranSPIen,
  input  logic [11:0] data2SPI,
  output logic        next_read,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_csn,
  output logic        busy
`ifdef SPI_WORD_TX_RXCAP_EN
  ,
  input  logic        spi_miso,
  output logic [11:0] rx_data,
  output logic        rx_valid
`endif
);

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = 4;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   div_q, div_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-2:0]   sr_q, sr_d;       // bits still to be sent after the current one
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            csn_q, csn_d;
  logic            nr_q, nr_d;
  logic            busy_q, busy_d;
`ifdef SPI_WORD_TX_RXCAP_EN
  logic [DW-1:0]   rx_sr_q, rx_sr_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
`endif

  // Next-state and output logic; counters reload at their terminal values.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    nr_d    = 1'b0;
`ifdef SPI_WORD_TX_RXCAP_EN
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (TranSPIen) state_d = LOAD;
      end
      LOAD: begin
        sr_d    = data2SPI[DW-2:0];
        mosi_d  = data2SPI[DW-1];
        csn_d   = 1'b0;
        sclk_d  = 1'b0;
        bit_d   = '0;
        div_d   = '0;
        state_d = SHIFT;
`ifdef SPI_WORD_TX_RXCAP_EN
        rx_sr_d = '0;
`endif
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
`ifdef SPI_WORD_TX_RXCAP_EN
            rx_sr_d = {rx_sr_q[DW-2:0], spi_miso};
`endif
          end else if (bit_q == BIT_LAST) begin
            sclk_d  = 1'b0;
            csn_d   = 1'b1;
            nr_d    = 1'b1;
            gap_d   = '0;
            state_d = GAP;
`ifdef SPI_WORD_TX_RXCAP_EN
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
`endif
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + BW'(1);
            mosi_d = sr_q[DW-2];
            sr_d   = {sr_q[DW-3:0], 1'b0};
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = TranSPIen ? LOAD : IDLE;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      nr_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SPI_WORD_TX_RXCAP_EN
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      nr_q    <= nr_d;
      busy_q  <= busy_d;
`ifdef SPI_WORD_TX_RXCAP_EN
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`endif
    end
  end

  assign next_read = nr_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_csn   = csn_q;
  assign busy      = busy_q;
`ifdef SPI_WORD_TX_RXCAP_EN
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
`endif

endmodule

// File: doc/spi_word_tx.md
SPI_WORD_TX -- requirements
Module: spi_word_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_GAP, default 4: clk cycles spi_csn is held high between words; legal range 3..255.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 TranSPIen  input  1  transfer enable from the upstream word memory; high while words remain.
REQ-006 data2SPI  input  12  current word from the upstream memory; valid 2 cycles after a next_read pulse.
REQ-007 next_read  output  1  one-cycle pulse requesting the next word from upstream.
REQ-008 spi_sclk  output  1  SPI clock, mode 0, idles low.
REQ-009 spi_mosi  output  1  serial data, MSB first.
REQ-010 spi_csn  output  1  active-low chip select, one assertion per word.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, LOAD, SHIFT, GAP.
REQ-013 IDLE: when TranSPIen=1, go to LOAD next cycle.
REQ-014 LOAD (1 cycle): shift register <= data2SPI; spi_csn <= 0; spi_mosi <= data2SPI[11]; bit counter <= 0; go to SHIFT.
REQ-015 SHIFT: spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit; 12 bits per word.
REQ-016 spi_mosi changes only on the cycle spi_sclk falls (next bit, MSB to LSB); it is stable during every high phase.
REQ-017 After the 12th high phase: spi_sclk <= 0, spi_csn <= 1, next_read pulses for exactly 1 cycle, go to GAP.
REQ-018 GAP: hold spi_csn=1 for CS_GAP cycles; then go to LOAD if TranSPIen=1, else go to IDLE.
REQ-019 Word frame length: 1 + 24*CLK_DIV + CS_GAP clk cycles; spi_csn low for exactly 24*CLK_DIV cycles.
REQ-020 A TranSPIen fall during LOAD or SHIFT does not truncate the word: the word completes, next_read still pulses, then the FSM goes to IDLE.
REQ-021 CS_GAP>=3 guarantees the upstream counter update plus its registered read have landed before the next LOAD samples data2SPI.
REQ-022 next_read is never asserted in IDLE or LOAD, and never twice per word.
REQ-023 Bit and divider counters saturate at their terminal values and reload; no wrap-around ever produces an extra SCLK edge.

Reset
REQ-024 rst=1 on a clock edge forces state=IDLE, spi_sclk=0, spi_mosi=0, spi_csn=1, next_read=0, busy=0, and clears all counters and the shift register.
REQ-025 rst mid-word aborts immediately with no further SCLK edges and no next_read pulse; rst has priority over all other inputs.

Configuration
REQ-026 Macro SPI_WORD_TX_RXCAP_EN: when defined, add ports spi_miso (input 1), rx_data (output 12) and rx_valid (output 1).
REQ-027 With SPI_WORD_TX_RXCAP_EN: spi_miso is sampled on each SCLK rising edge, MSB first, into rx_data; rx_valid pulses in the same cycle as next_read; rx_data holds until the next word; rx_data and rx_valid reset to 0.
REQ-028 Without SPI_WORD_TX_RXCAP_EN: the three ports and their logic are absent; all other behaviour is identical.

Verification (CLK_DIV=2, CS_GAP=3 unless noted)
REQ-029 Single word: data2SPI=12'hA5C, TranSPIen held high 1 cycle then dropped -> MOSI bits 1010_0101_1100 on 12 SCLK rising edges; spi_csn low for 48 cycles; one next_read pulse; return to IDLE.
REQ-030 Burst of 10 words: upstream model (counter+1 on next_read, registered read, TranSPIen falls at count 10) loaded with 12'h001..12'h00A -> 10 frames of 52 cycles each carrying 001..00A in order, 10 next_read pulses, then IDLE.
REQ-031 Mid-word enable drop: TranSPIen falls on the 5th bit -> all 12 bits are sent, next_read pulses once, FSM reaches IDLE, and no further LOAD occurs.
REQ-032 Reset mid-word: rst=1 on the 7th bit -> next cycle spi_csn=1, spi_sclk=0, busy=0, and no next_read pulse.
REQ-033 CLK_DIV=1: word 12'hFFF -> SCLK period 2 cycles; frame length 1+24+3=28 cycles.
REQ-034 SPI_WORD_TX_RXCAP_EN defined, spi_miso looped to spi_mosi, word 12'h3C7 -> rx_data=12'h3C7 with rx_valid coincident with next_read.
